// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states, opcodes,
// ALU operation encodings and datapath select codes.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_e;

    // Which decode rules the ALU-op decoder applies in the current state
    typedef enum logic [1:0] {
        OPC_ADD,
        OPC_R,
        OPC_I,
        OPC_BRANCH
    } op_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational funct3/funct7 decode into an ALU operation plus an illegal-encoding flag.
// Illegal encodings report add so the datapath sees a benign operation.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  op_class_e   i_class,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    output logic [3:0]  o_aluc,
    output logic        o_illegal
);

    logic w_is_r;
    logic w_alt;

    assign w_is_r = (i_class == OPC_R);
    assign w_alt  = (i_funct7 == 7'b0100000);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
        o_aluc    = ALU_ADD;
        o_illegal = 1'b0;
        case (i_class)
            OPC_R, OPC_I: begin
                case (i_funct3)
                    3'b000:  o_aluc = (w_is_r && i_funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_aluc = ALU_SLL;
                    3'b010:  o_aluc = ALU_SLT;
                    3'b011:  o_aluc = ALU_SLTU;
                    3'b100:  o_aluc = ALU_XOR;
                    3'b101:  o_aluc = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  o_aluc = ALU_OR;
                    default: o_aluc = ALU_AND;
                endcase
                // I-type funct7 is immediate data except for the shift-amount forms
                if (w_is_r) begin
                    o_illegal = !((i_funct7 == 7'b0000000) ||
                                  (w_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
                end else if (i_funct3 == 3'b001) begin
                    o_illegal = (i_funct7 != 7'b0000000);
                end else if (i_funct3 == 3'b101) begin
                    o_illegal = !((i_funct7 == 7'b0000000) || w_alt);
                end
                if (o_illegal) begin
                    o_aluc = ALU_ADD;
                end
            end
            OPC_BRANCH: begin
                o_aluc    = ALU_SUB;
                o_illegal = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the datapath enables, operand selects and ALU operation for each state.
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned RESET_FETCH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        cout,
    input  logic        overflow,
    input  logic        sign,
    output logic        pc_write,
    output logic        old_pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  aluc,
    output logic [1:0]  result_src,
    output logic        fault
);

    localparam state_e RESET_STATE = (RESET_FETCH != 0) ? S_FETCH : S_IDLE;

    state_e      r_state;
    state_e      w_next;
    op_class_e   w_class;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [3:0]  w_aluc;
    logic        w_illegal;
    logic        w_taken;
    logic        w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    // NOTE: state uses non-blocking assignment; the synchronous reset is just the highest-priority branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        case (r_state)
            S_EXEC_R: w_class = OPC_R;
            S_EXEC_I: w_class = OPC_I;
            S_BRANCH: w_class = OPC_BRANCH;
            default:  w_class = OPC_ADD;
        endcase
    end

    alu_op_decode u_alu_op_decode (
        .i_class   (w_class),
        .i_funct3  (w_funct3),
        .i_funct7  (instr[31:25]),
        .o_aluc    (w_aluc),
        .o_illegal (w_illegal)
    );

    // Branch condition from the flags of the rs1 - rs2 subtraction
    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = sign ^ overflow;
            3'b101:  w_taken = ~(sign ^ overflow);
            3'b110:  w_taken = ~cout;
            3'b111:  w_taken = cout;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        pc_write     = 1'b0;
        old_pc_write = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        aluc         = ALU_ADD;
        result_src   = RES_ALUOUT;
        fault        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    old_pc_write = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (w_opcode)
                    OP_R:               w_next = S_EXEC_R;
                    OP_I:               w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
                    OP_BRANCH:          w_next = S_BRANCH;
                    OP_JAL:             w_next = S_JAL;
                    OP_JALR:            w_next = S_JALR1;
                    OP_LUI:             w_next = S_LUI;
                    OP_AUIPC:           w_next = S_AUIPC;
                    default:            w_next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = (r_state == S_EXEC_R) ? SRC_B_RS2 : SRC_B_IMM;
                aluc      = w_aluc;
                w_next    = w_illegal ? S_TRAP : S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                w_next     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                w_next    = (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                aluc      = w_aluc;
                pc_write  = w_taken & ~w_illegal;
                w_next    = w_illegal ? S_TRAP : S_FETCH;
            end
            S_JAL, S_JALR2: begin
                // rd = old_pc + 4 from the live ALU; PC loads the target held in ALU-out
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                reg_write  = 1'b1;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JALR1: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                w_next    = S_JALR2;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                w_next    = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                w_next    = S_ALU_WB;
            end
            S_TRAP: begin
                fault = 1'b1;
            end
            default: w_next = S_TRAP;
        endcase

        // Reset forces every output low in the same cycle, dropping any pending request
        if (rst) begin
            pc_write     = 1'b0;
            old_pc_write = 1'b0;
            ir_write     = 1'b0;
            iord         = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            reg_write    = 1'b0;
            alu_src_a    = SRC_A_PC;
            alu_src_b    = SRC_B_RS2;
            aluc         = ALU_ADD;
            result_src   = RES_ALUOUT;
            fault        = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each instruction expands into its expected
// per-cycle output sequence; a negedge monitor pops and compares every cycle.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       old_pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] aluc;
        logic [1:0] result_src;
        logic       fault;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0, cout = 1'b0, overflow = 1'b0, sign = 1'b0;
    logic        pc_write, old_pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  aluc;
    logic        fault;
    obs_t        act;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // ALU op per funct3 for the base (non-alternate) encoding
    localparam logic [3:0] F3_OP [8] = '{4'h0, 4'h7, 4'h5, 4'h8, 4'h9, 4'h6, 4'h3, 4'h2};
    localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    mc_control_fsm #(.RESET_FETCH(1)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .mem_ready(mem_ready),
        .zero(zero), .cout(cout), .overflow(overflow), .sign(sign),
        .pc_write(pc_write), .old_pc_write(old_pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluc(aluc),
        .result_src(result_src), .fault(fault)
    );

    always #5 clk = ~clk;

    assign act = {pc_write, old_pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                  alu_src_a, alu_src_b, aluc, result_src, fault};

    always @(negedge clk) begin
        obs_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s @%0t: got %b expected %b (pc,opc,ir,iord,rd,wr,rw,a,b,aluc,res,fault)",
                         nm, $time, act, e);
            end
        end
    end

    function automatic bit legal_alu(input logic [2:0] f3, input logic [6:0] f7,
                                     input bit is_r, output logic [3:0] op);
        bit shift;
        bit ok;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        op = F3_OP[f3];
        if (is_r) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20 && f3 == 3'd0) op = 4'h1;
        end else begin
            ok = !shift || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        end
        if (f3 == 3'd5 && f7 == 7'h20) op = 4'h4;
        if (!ok) op = 4'h0;
        return ok;
    endfunction

    function automatic bit branch_ref(input logic [2:0] f3, output bit taken);
        bit lt_s;
        lt_s  = (sign != overflow);
        taken = 1'b0;
        case (f3)
            3'd0: taken = zero;
            3'd1: taken = !zero;
            3'd4: taken = lt_s;
            3'd5: taken = !lt_s;
            3'd6: taken = !cout;
            3'd7: taken = cout;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic step(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        {zero, cout, overflow, sign} = 4'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic do_reset(input int n);
        obs_t e;
        e = '0;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise();
            step(e, "reset");
        end
        rst = 1'b0;
    endtask

    task automatic front(input logic [31:0] ins, input int fw);
        obs_t e;
        instr = ins;
        e = '0;
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b10;
        for (int i = 0; i < fw; i++) begin
            noise();
            mem_ready = 1'b0;
            step(e, "fetch_wait");
        end
        noise();
        mem_ready = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        e.old_pc_write = 1'b1;
        step(e, "fetch");
        e = '0;
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b01;
        noise();
        step(e, "decode");
    endtask

    task automatic wb_cycle(input logic [1:0] src, input string nm);
        obs_t e;
        e = '0;
        e.reg_write  = 1'b1;
        e.result_src = src;
        noise();
        step(e, nm);
    endtask

    task automatic link_cycle(input string nm);
        obs_t e;
        e = '0;
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b10;
        e.reg_write = 1'b1;
        e.result_src = 2'b10;
        e.pc_write = 1'b1;
        noise();
        step(e, nm);
    endtask

    // waits < 0 picks random memory latencies; hold is the number of TRAP cycles checked
    task automatic run_instr(input logic [31:0] ins, input int waits, input bit force_bf,
                             input logic [3:0] bf, input int hold);
        obs_t e;
        logic [3:0] op;
        bit ok;
        bit taken;
        bit is_load;
        int dw;
        front(ins, (waits < 0) ? int'($urandom_range(0, 2)) : 0);
        dw = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
        ok = 1'b1;
        e = '0;
        case (ins[6:0])
            7'h33, 7'h13: begin
                ok = legal_alu(ins[14:12], ins[31:25], ins[6:0] == 7'h33, op);
                e.alu_src_a = 2'b10;
                e.alu_src_b = (ins[6:0] == 7'h33) ? 2'b00 : 2'b01;
                e.aluc = op;
                noise();
                step(e, "exec");
                if (ok) wb_cycle(2'b00, "alu_wb");
            end
            7'h03, 7'h23: begin
                is_load = (ins[6:0] == 7'h03);
                e.alu_src_a = 2'b10;
                e.alu_src_b = 2'b01;
                noise();
                step(e, "mem_addr");
                e = '0;
                e.iord = 1'b1;
                e.mem_read = is_load;
                e.mem_write = !is_load;
                for (int i = 0; i < dw; i++) begin
                    noise();
                    mem_ready = 1'b0;
                    step(e, "mem_wait");
                end
                noise();
                mem_ready = 1'b1;
                step(e, "mem_done");
                if (is_load) wb_cycle(2'b01, "mem_wb");
            end
            7'h63: begin
                noise();
                if (force_bf) {zero, cout, overflow, sign} = bf;
                ok = branch_ref(ins[14:12], taken);
                e.alu_src_a = 2'b10;
                e.alu_src_b = 2'b00;
                e.aluc = 4'h1;
                e.pc_write = taken;
                step(e, "branch");
            end
            7'h6F: link_cycle("jal");
            7'h67: begin
                e.alu_src_a = 2'b10;
                e.alu_src_b = 2'b01;
                noise();
                step(e, "jalr1");
                link_cycle("jalr2");
            end
            7'h37, 7'h17: begin
                e.alu_src_a = (ins[6:0] == 7'h37) ? 2'b11 : 2'b01;
                e.alu_src_b = 2'b01;
                noise();
                step(e, "upper_imm");
                wb_cycle(2'b00, "alu_wb");
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            e.fault = 1'b1;
            for (int i = 0; i < hold; i++) begin
                noise();
                step(e, "trap");
            end
            do_reset(1);
        end
    endtask

    task automatic store_reset_mid_wr();
        obs_t e;
        front(32'h0020A023, 0);
        e = '0;
        e.alu_src_a = 2'b10;
        e.alu_src_b = 2'b01;
        noise();
        step(e, "sw_addr");
        e = '0;
        e.iord = 1'b1;
        e.mem_write = 1'b1;
        for (int i = 0; i < 2; i++) begin
            noise();
            mem_ready = 1'b0;
            step(e, "sw_wait");
        end
        e = '0;
        rst = 1'b1;
        mem_ready = 1'b0;
        step(e, "rst_mid_wr");
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) r[6:0] = OPS[k];
        if ((k < 2) && ($urandom_range(0, 3) != 0)) begin
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset(2);
        run_instr(32'h002081B3, 0, 1'b0, 4'h0, 0);           // add
        run_instr(32'h402081B3, 0, 1'b0, 4'h0, 0);           // sub
        run_instr(32'h00208063, 0, 1'b1, 4'b1000, 0);        // beq, zero=1
        run_instr(32'h00208063, 0, 1'b1, 4'b0000, 0);        // beq, zero=0
        run_instr(32'h0020C063, 0, 1'b1, 4'b0001, 0);        // blt, sign=1 ovf=0
        run_instr(32'h0020C063, 0, 1'b1, 4'b0011, 0);        // blt, sign=1 ovf=1
        run_instr(32'h0020E063, 0, 1'b1, 4'b0000, 0);        // bltu, cout=0
        run_instr(32'h0000A183, 3, 1'b0, 4'h0, 0);           // lw, 3 wait cycles
        run_instr(32'hFFFFFFFF, 0, 1'b0, 4'h0, 12);          // illegal opcode
        run_instr(32'h002081B3, 0, 1'b0, 4'h0, 0);
        store_reset_mid_wr();
        run_instr(32'h002081B3, 0, 1'b0, 4'h0, 0);
        for (int n = 0; n < 150; n++) begin
            run_instr(rand_instr(), -1, 1'b0, 4'h0, int'($urandom_range(1, 6)));
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
